// File: rtl/acondicionador_botones_pkg.sv
// Shared definitions for the push-button conditioner: debouncer FSM state
// encodings and the default instance sizing.
package acondicionador_botones_pkg;

  localparam int CANT_BOTONES_DEF   = 4;
  localparam int CICLOS_ESTABLE_DEF = 1_000_000;

  typedef enum logic [1:0] {
    REPOSO      = 2'b00,
    VALIDA_ALTO = 2'b01,
    PRESIONADO  = 2'b10,
    VALIDA_BAJO = 2'b11
  } estado_e;

  // The accepted level is high while pressed or while a release is still unproven.
  function automatic logic es_nivel_alto(input estado_e estado);
    return (estado == PRESIONADO) || (estado == VALIDA_BAJO);
  endfunction

endpackage

// File: rtl/acondicionador_botones_debouncer.sv
// One button: 2-flop synchronizer, debounce FSM and stability counter.
// Raises a combinational press candidate on the edge the press is accepted.
module debouncer_boton
  import acondicionador_botones_pkg::*;
#(
  parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic nivel,
  output logic candidato
);

  localparam int               ANCHO  = $clog2(CICLOS_ESTABLE + 1);
  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(CICLOS_ESTABLE - 1);
  localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

  logic [1:0]       sincro;
  logic             sinc;
  estado_e          estado, estado_sig;
  logic [ANCHO-1:0] contador, contador_sig;

  // NOTE: every clocked process uses non-blocking assignments so that all
  // flops sample their inputs from the same edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sincro <= '0;
    end else begin
      sincro <= {sincro[0], raw};
    end
  end

  assign sinc = sincro[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= REPOSO;
      contador <= '0;
      nivel    <= 1'b0;
    end else begin
      estado   <= estado_sig;
      contador <= contador_sig;
      nivel    <= es_nivel_alto(estado_sig);
    end
  end

  // NOTE: defaults are assigned before the case so no path leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_sig   = estado;
    contador_sig = contador;
    candidato    = 1'b0;
    unique case (estado)
      REPOSO: begin
        if (sinc) begin
          estado_sig   = VALIDA_ALTO;
          contador_sig = '0;
        end
      end
      VALIDA_ALTO: begin
        if (!sinc) begin
          estado_sig = REPOSO;
        end else if (contador == ULTIMO) begin
          estado_sig = PRESIONADO;
          candidato  = 1'b1;
        end else begin
          contador_sig = contador + UNO;
        end
      end
      PRESIONADO: begin
        if (!sinc) begin
          estado_sig   = VALIDA_BAJO;
          contador_sig = '0;
        end
      end
      VALIDA_BAJO: begin
        // A bounce back to pressed returns silently; only real presses pulse.
        if (sinc) begin
          estado_sig = PRESIONADO;
        end else if (contador == ULTIMO) begin
          estado_sig = REPOSO;
        end else begin
          contador_sig = contador + UNO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Push-button conditioner: per-button debouncers, lowest-index-wins press
// arbiter and the registered one-hot press pulse output.
module acondicionador_botones
  import acondicionador_botones_pkg::*;
#(
  parameter int CANT_BOTONES   = CANT_BOTONES_DEF,
  parameter int CICLOS_ESTABLE = CICLOS_ESTABLE_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [CANT_BOTONES-1:0] i_botones_raw,
  output logic [CANT_BOTONES-1:0] o_botones,
  output logic [CANT_BOTONES-1:0] o_niveles
);

  logic [CANT_BOTONES-1:0] candidatos;
  logic [CANT_BOTONES-1:0] niveles;
  logic [CANT_BOTONES-1:0] ganador;
  logic                    tomado;

  for (genvar g = 0; g < CANT_BOTONES; g++) begin : g_boton
    debouncer_boton #(
      .CICLOS_ESTABLE(CICLOS_ESTABLE)
    ) u_debouncer (
      .clk      (i_clock),
      .rst_n    (i_reset),
      .raw      (i_botones_raw[g]),
      .nivel    (niveles[g]),
      .candidato(candidatos[g])
    );
  end

  // Losing candidates are simply dropped: their FSMs still enter PRESIONADO.
  always_comb begin
    ganador = '0;
    tomado  = 1'b0;
    for (int i = 0; i < CANT_BOTONES; i++) begin
      if (candidatos[i] && !tomado) begin
        ganador[i] = 1'b1;
        tomado     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_botones <= '0;
    end else begin
      o_botones <= ganador;
    end
  end

  // Levels are already registered alongside each FSM state.
  assign o_niveles = niveles;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Self-checking bench for acondicionador_botones: directed scenarios with
// literal expectations plus randomized bouncing against a behavioural model.
module tb_acondicionador_botones;

  localparam int N = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] o_botones;
  logic [N-1:0] o_niveles;

  int total = 0;
  int bad   = 0;

  acondicionador_botones #(
    .CANT_BOTONES  (N),
    .CICLOS_ESTABLE(C)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_botones_raw(raw),
    .o_botones    (o_botones),
    .o_niveles    (o_niveles)
  );

  always #5 clk = ~clk;

  task automatic check(input string nombre, input logic [N-1:0] actual,
                       input logic [N-1:0] esperado);
    total++;
    if (actual !== esperado) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", nombre, $time, actual, esperado);
    end
  endtask

  // Model: the debouncer sees raw two edges late; a button's accepted level
  // flips once it has disagreed with the sampled value on C+1 consecutive edges.
  logic [N-1:0] h1, h2, acc, exp_pulso, exp_nivel;
  int           run [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1        <= '0;
      h2        <= '0;
      acc       <= '0;
      exp_pulso <= '0;
      exp_nivel <= '0;
      for (int i = 0; i < N; i++) run[i] <= 0;
    end else begin
      logic [N-1:0] acc_n, subida, primero;
      acc_n   = acc;
      subida  = '0;
      primero = '0;
      for (int i = 0; i < N; i++) begin
        if (h2[i] != acc[i]) begin
          if (run[i] == C) begin
            acc_n[i]  = h2[i];
            subida[i] = h2[i];
            run[i]   <= 0;
          end else begin
            run[i] <= run[i] + 1;
          end
        end else begin
          run[i] <= 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (subida[i] && primero == '0) primero[i] = 1'b1;
      end
      h1        <= raw;
      h2        <= h1;
      acc       <= acc_n;
      exp_pulso <= primero;
      exp_nivel <= acc_n;
    end
  end

  always @(negedge clk) begin
    check("modelo_pulso", o_botones, exp_pulso);
    check("modelo_nivel", o_niveles, exp_nivel);
  end

  // Edge 0 is the next rising edge; checks are made just after each edge.
  task automatic ventana(input string n, input logic [N-1:0] pulso, input int e_pulso,
                         input logic [N-1:0] nivel, input int e_nivel, input int largo);
    @(posedge clk);
    for (int e = 0; e < largo; e++) begin
      @(negedge clk);
      check({n, "_pulso"}, o_botones, (e == e_pulso) ? pulso : '0);
      check({n, "_nivel"}, o_niveles, (e >= e_nivel) ? nivel : '0);
    end
  endtask

  task automatic reposo(input int ciclos);
    @(negedge clk);
    raw = '0;
    repeat (ciclos) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    repeat (3) @(negedge clk);
    check("reset_pulso", o_botones, 4'b0000);
    check("reset_nivel", o_niveles, 4'b0000);

    // Single press held from before edge 0.
    raw   = 4'b0001;
    rst_n = 1'b1;
    ventana("press", 4'b0001, 6, 4'b0001, 6, 14);
    reposo(12);

    // Bouncing bit 2 never settles long enough to be accepted.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("rebote_pulso", o_botones, 4'b0000);
      check("rebote_nivel", o_niveles, 4'b0000);
      raw = (i < 10 && i % 2 == 0) ? 4'b0100 : 4'b0000;
    end
    reposo(4);

    // Simultaneous acceptance: lowest index wins, both levels rise.
    raw = 4'b0110;
    ventana("simult", 4'b0010, 6, 4'b0110, 6, 16);
    reposo(12);

    // Accepted press followed by a one-cycle release glitch.
    raw = 4'b0001;
    ventana("glitch_a", 4'b0001, 6, 4'b0001, 6, 10);
    @(negedge clk);
    raw = 4'b0000;
    @(negedge clk);
    raw = 4'b0001;
    ventana("glitch_b", 4'b0000, -1, 4'b0001, 0, 14);
    reposo(12);

    // Reset in the middle of validation; button still held at release.
    raw = 4'b0100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_pulso", o_botones, 4'b0000);
      check("rst_mid_nivel", o_niveles, 4'b0000);
    end
    rst_n = 1'b1;
    ventana("rst_mid", 4'b0100, 6, 4'b0100, 6, 12);
    reposo(12);

    // Random bouncing on every bit with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      @(negedge clk);
      v = raw;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
      end
      raw = v;
      if ($urandom_range(0, 399) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    reposo(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
